// File: rtl/divider_multi_radix_if.sv
// Request/response bundle shared by the M-extension divider and its issuer.
// Operand, op and kill flow from master to slave; result and status flow back.
interface divider_multi_radix_if #(
  parameter int XLEN         = 32,
  parameter int DIV_OP_WIDTH = 2
);
  logic                    valid;
  logic [DIV_OP_WIDTH-1:0] DIVop;
  logic [XLEN-1:0]         divident;
  logic [XLEN-1:0]         divisor;
  logic                    kill;
  logic                    ready;
  logic                    busy;
  logic [XLEN-1:0]         divOrRemRslt;
  logic                    div_by_zero_err;

  modport master (
    output valid, DIVop, divident, divisor, kill,
    input  ready, busy, divOrRemRslt, div_by_zero_err
  );

  modport slave (
    input  valid, DIVop, divident, divisor, kill,
    output ready, busy, divOrRemRslt, div_by_zero_err
  );
endinterface

// File: rtl/divider_multi_radix.sv
// Iterative restoring divider (RISC-V DIV/DIVU/REM/REMU), BITS_PER_CYCLE quotient
// bits per clock, with early exit for divide-by-zero and signed overflow.
module divider_multi_radix #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1
) (
  input logic                  clk,
  input logic                  reset,
  divider_multi_radix_if.slave bus
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0]   LAST = CW'(N - 1);
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE = 3'b001, CALC = 3'b010, FIX = 3'b100} state_t;
  state_t state_r, next_state_s;

  logic            rem_op_r, neg_q_r, neg_r_r, dz_r, ovf_r;
  logic [XLEN-1:0] raw_a_r, dvs_r, quo_r, rem_r, rslt_r;
  logic            err_r, ready_r, busy_r;
  logic [CW-1:0]   cnt_r;

  logic            accept_s, a_neg_s, b_neg_s, dz_s, ovf_s, special_s;
  logic [XLEN-1:0] a_abs_s, b_abs_s, quo_step_s, rem_step_s, fix_s;

  // Acceptance qualification and operand preconditioning (DIVop[0]=1: unsigned, DIVop[1]=1: remainder)
  always_comb begin
    accept_s  = (state_r == IDLE) && bus.valid && !ready_r && !bus.kill;
    a_neg_s   = !bus.DIVop[0] && bus.divident[XLEN-1];
    b_neg_s   = !bus.DIVop[0] && bus.divisor[XLEN-1];
    a_abs_s   = a_neg_s ? (ZERO - bus.divident) : bus.divident;
    b_abs_s   = b_neg_s ? (ZERO - bus.divisor) : bus.divisor;
    dz_s      = (bus.divisor == ZERO);
    ovf_s     = !bus.DIVop[0] && (bus.divident == MIN) && (bus.divisor == ONES);
    special_s = dz_s || ovf_s;
  end

  // Chain of restoring steps; remainder stays below divisor so XLEN bits hold it
  always_comb begin
    logic [XLEN-1:0] r_v, q_v;
    logic [XLEN:0]   rp_v;
    logic [XLEN+1:0] diff_v;
    r_v    = rem_r;
    q_v    = quo_r;
    rp_v   = {(XLEN+1){1'b0}};
    diff_v = {(XLEN+2){1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rp_v   = {r_v, q_v[XLEN-1]};
      diff_v = {1'b0, rp_v} - {2'b00, dvs_r};
      q_v    = {q_v[XLEN-2:0], ~diff_v[XLEN+1]};
      if (diff_v[XLEN+1]) begin
        r_v = rp_v[XLEN-1:0];
      end else begin
        r_v = diff_v[XLEN-1:0];
      end
    end
    rem_step_s = r_v;
    quo_step_s = q_v;
  end

  // Final result selection with RISC-V special-case values
  always_comb begin
    fix_s = ZERO;
    if (dz_r) begin
      fix_s = rem_op_r ? raw_a_r : ONES;
    end else if (ovf_r) begin
      fix_s = rem_op_r ? ZERO : MIN;
    end else if (rem_op_r) begin
      fix_s = neg_r_r ? (ZERO - rem_r) : rem_r;
    end else begin
      fix_s = neg_q_r ? (ZERO - quo_r) : quo_r;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = (special_s && (EARLY_OUT != 0)) ? FIX : CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (bus.kill) begin
          next_state_s = IDLE;
        end else if (cnt_r == LAST) begin
          next_state_s = FIX;
        end else begin
          next_state_s = CALC;
        end
      end
      FIX:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand latch, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_op_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
      raw_a_r  <= ZERO;
      dvs_r    <= ZERO;
      quo_r    <= ZERO;
      rem_r    <= ZERO;
      cnt_r    <= {CW{1'b0}};
      rslt_r   <= ZERO;
      err_r    <= 1'b0;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      ready_r <= (state_r == FIX) && !bus.kill;
      busy_r  <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            rem_op_r <= bus.DIVop[1];
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            dz_r     <= dz_s;
            ovf_r    <= ovf_s;
            raw_a_r  <= bus.divident;
            dvs_r    <= b_abs_s;
            quo_r    <= a_abs_s;
            rem_r    <= ZERO;
            cnt_r    <= {CW{1'b0}};
          end
        end
        CALC: begin
          quo_r <= quo_step_s;
          rem_r <= rem_step_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          if (!bus.kill) begin
            rslt_r <= fix_s;
            err_r  <= dz_r;
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.ready           = ready_r;
  assign bus.busy            = busy_r;
  assign bus.divOrRemRslt    = rslt_r;
  assign bus.div_by_zero_err = err_r;
endmodule

// File: tb/tb_divider_multi_radix.sv
// Directed-vector bench for divider_multi_radix: three builds (k=1 early-out,
// k=1 full-run, k=4) checked against hand-computed RISC-V results and latencies.
module tb_divider_multi_radix;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  divider_multi_radix_if #(.XLEN(32)) b1 ();
  divider_multi_radix_if #(.XLEN(32)) b0 ();
  divider_multi_radix_if #(.XLEN(32)) b4 ();

  divider_multi_radix #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1)) u_k1 (.clk(clk), .reset(reset), .bus(b1));
  divider_multi_radix #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(0)) u_k1_full (.clk(clk), .reset(reset), .bus(b0));
  divider_multi_radix #(.XLEN(32), .BITS_PER_CYCLE(4), .EARLY_OUT(1)) u_k4 (.clk(clk), .reset(reset), .bus(b4));

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int busy_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic k, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    case (sel)
      0: begin b1.valid = v; b1.kill = k; b1.DIVop = op; b1.divident = a; b1.divisor = b; end
      1: begin b0.valid = v; b0.kill = k; b0.DIVop = op; b0.divident = a; b0.divisor = b; end
      default: begin b4.valid = v; b4.kill = k; b4.DIVop = op; b4.divident = a; b4.divisor = b; end
    endcase
  endtask

  // {ready, busy, err, result}
  function automatic logic [34:0] obs(input int sel);
    case (sel)
      0:       return {b1.ready, b1.busy, b1.div_by_zero_err, b1.divOrRemRslt};
      1:       return {b0.ready, b0.busy, b0.div_by_zero_err, b0.divOrRemRslt};
      default: return {b4.ready, b4.busy, b4.div_by_zero_err, b4.divOrRemRslt};
    endcase
  endfunction

  // Waits (bounded) for ready; lat counts cycles since the accepting edge
  task automatic wait_rdy(input int sel, input int start, output int lat);
    logic [34:0] o;
    lat = start;
    busy_cnt = 0;
    o = obs(sel);
    while (!o[34] && lat < 200) begin
      if (o[33]) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      o = obs(sel);
    end
  endtask

  task automatic run(input int sel, input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_r, input logic exp_err, input int exp_lat);
    int lat;
    logic [34:0] o;
    drive(sel, 1'b1, 1'b0, op, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, op, a, b);
    wait_rdy(sel, 1, lat);
    o = obs(sel);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, {32'h0, o[31:0]}, {32'h0, exp_r});
    chk({tag, " err"}, {63'h0, o[32]}, {63'h0, exp_err});
    chk({tag, " busy at ready"}, {63'h0, o[33]}, 64'h0);
    @(posedge clk); #1;
    o = obs(sel);
    chk({tag, " ready pulse width"}, {63'h0, o[34]}, 64'h0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [34:0] o;
    reset = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, OP_DIV, 32'h0, 32'h0);
    #12;
    for (int s = 0; s < 3; s++) chk("reset state", {29'h0, obs(s)}, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run(0, "DIV 100/7", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 34);
    chk("DIV 100/7 busy cycles", 64'(busy_cnt), 64'd33);
    run(0, "REM 100/7", OP_REM, 32'd100, 32'd7, 32'd2, 1'b0, 34);
    run(0, "DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34);
    run(0, "REM -7/2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34);
    run(0, "DIVU -7/2", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 1'b0, 34);
    run(0, "REMU -7/2", OP_REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 1'b0, 34);
    run(0, "DIVU x/0", OP_DIVU, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b1, 2);
    run(0, "REMU x/0", OP_REMU, 32'h12345678, 32'h0, 32'h12345678, 1'b1, 2);
    run(0, "DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2);
    run(0, "REM ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2);
    run(0, "DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);

    // Kill in CALC at T+5
    drive(0, 1'b1, 1'b0, OP_DIVU, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, OP_DIVU, 32'd1000, 32'd3);
    pulses = 0;
    for (int i = 1; i < 5; i++) begin
      if (obs(0)[34]) pulses++;
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b1, OP_DIVU, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, OP_DIVU, 32'd1000, 32'd3);
    o = obs(0);
    chk("kill busy", {63'h0, o[33]}, 64'h0);
    chk("kill ready", 64'(pulses + int'(o[34])), 64'h0);
    chk("kill result held", {32'h0, o[31:0]}, 64'd14);

    // Reissue at T+6; operand change two cycles later must not matter
    drive(0, 1'b1, 1'b0, OP_DIVU, 32'd9, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, OP_DIVU, 32'd9, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, OP_DIV, 32'd1000, 32'd1);
    wait_rdy(0, 2, lat);
    chk("post-kill DIVU 9/3 latency", 64'(lat), 64'd34);
    chk("post-kill DIVU 9/3 result", {32'h0, obs(0)[31:0]}, 64'd3);
    @(posedge clk); #1;

    // kill together with valid in IDLE
    drive(0, 1'b1, 1'b1, OP_DIVU, 32'd50, 32'd5);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, OP_DIVU, 32'd50, 32'd5);
    chk("kill+valid busy", {63'h0, obs(0)[33]}, 64'h0);
    @(posedge clk); #1;
    chk("kill+valid busy later", {63'h0, obs(0)[33]}, 64'h0);

    // Async reset mid-CALC at T+10
    drive(0, 1'b1, 1'b0, OP_DIVU, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, OP_DIVU, 32'd1000, 32'd3);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    o = obs(0);
    chk("pre-reset busy", {63'h0, o[33]}, 64'h1);
    chk("pre-reset result", {32'h0, o[31:0]}, 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("async reset outputs", {29'h0, obs(0)}, 64'h0);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    run(1, "full DIVU x/0", OP_DIVU, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b1, 34);
    run(1, "full REMU x/0", OP_REMU, 32'h12345678, 32'h0, 32'h12345678, 1'b1, 34);
    run(1, "full DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34);

    run(2, "k4 DIVU", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 1'b0, 10);
    run(2, "k4 DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 10);
    run(2, "k4 REM 100/7", OP_REM, 32'd100, 32'd7, 32'd2, 1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
